cam_frame_capture_ctrl: RTL

- Capture sequencer between the CameraLink-to-AXIS receiver output and downstream video consumers (VDMA and similar), all on the AXIS clock.
- Gates whole frames under software control: start, stop, and N-frame or continuous capture.
- Always aligns to a start of frame and discards partial frames.
- Checks line and frame geometry against configured width and height, and reports sticky errors plus a frame count.

---
 rtl/cam_frame_capture_ctrl_if.sv | 39 +++
 rtl/cam_frame_capture_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cam_frame_capture_ctrl_if.sv
// ---------------------------------------------------------------------------
// cam_frame_capture_ctrl_if
// AXI4-Stream video beat bundle shared by the capture sequencer and its
// neighbours.
//   tdata  : pixel beat
//   tvalid : beat valid (master -> slave)
//   tready : beat accepted (slave -> master)
//   tlast  : end of line
//   tuser  : bit 0 = start of frame
// Modports:
//   master : drives tdata/tvalid/tlast/tuser, samples tready
//   slave  : samples tdata/tvalid/tlast/tuser, drives tready
// ---------------------------------------------------------------------------
interface cam_frame_capture_ctrl_if #(
    parameter int DATA_WIDTH = 24,
    parameter int USER_WIDTH = 1
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;

    modport master (
        output tdata,
        output tvalid,
        input  tready,
        output tlast,
        output tuser
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready,
        input  tlast,
        input  tuser
    );
endinterface

// File: rtl/cam_frame_capture_ctrl.sv
// ---------------------------------------------------------------------------
// cam_frame_capture_ctrl
// Frame-aligned capture gate between the CameraLink-to-AXIS receiver and
// downstream video consumers. Whole frames are forwarded under software
// control (single, N-frame or continuous runs); partial frames before the
// first start of frame are dropped. Line and frame geometry is checked
// against the configured width/height with sticky error flags.
//
// Ports:
//   axis_clk           sole clock
//   rst                asynchronous, active-high reset
//   s_axis             beats from the receiver (slave modport)
//   m_axis             gated beats to the consumer (master modport)
//   cfg_width          pixels per line (latched at start)
//   cfg_height         lines per frame (latched at start)
//   cfg_num_frames     frames per run, 0 = continuous (latched at start)
//   ctrl_start         start pulse (honoured only in IDLE)
//   ctrl_stop          stop pulse (finishes the current frame first)
//   err_clear          clears sticky errors
//   sts_busy           high whenever not IDLE
//   sts_done           one-cycle pulse when a run ends
//   sts_frame_cnt      complete frames forwarded in this run
//   sts_err_line_len   sticky: a line length differed from cfg_width
//   sts_err_frame_len  sticky: a frame was cut short by a new start of frame
//
// States:
//   IDLE     | gate closed, beats discarded, waiting for ctrl_start
//   WAIT_SOF | run active, discarding until a start-of-frame beat
//   PASS     | forwarding a frame, counting pixels and lines
// ---------------------------------------------------------------------------
module cam_frame_capture_ctrl #(
    parameter int DATA_WIDTH = 24,
    parameter int USER_WIDTH = 1,
    parameter int CNT_WIDTH  = 12,
    parameter int FCNT_WIDTH = 16
) (
    input  logic                  axis_clk,
    input  logic                  rst,

    cam_frame_capture_ctrl_if.slave  s_axis,
    cam_frame_capture_ctrl_if.master m_axis,

    input  logic [CNT_WIDTH-1:0]  cfg_width,
    input  logic [CNT_WIDTH-1:0]  cfg_height,
    input  logic [FCNT_WIDTH-1:0] cfg_num_frames,
    input  logic                  ctrl_start,
    input  logic                  ctrl_stop,
    input  logic                  err_clear,

    output logic                  sts_busy,
    output logic                  sts_done,
    output logic [FCNT_WIDTH-1:0] sts_frame_cnt,
    output logic                  sts_err_line_len,
    output logic                  sts_err_frame_len
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        PASS     = 2'd2
    } state_t;

    state_t                state;
    logic                  tuser_d;
    logic                  stop_pending;
    logic [CNT_WIDTH-1:0]  pix_cnt;
    logic [CNT_WIDTH-1:0]  line_cnt;
    logic [CNT_WIDTH-1:0]  width_q;
    logic [CNT_WIDTH-1:0]  height_q;
    logic [FCNT_WIDTH-1:0] num_frames_q;
    logic [FCNT_WIDTH-1:0] frame_cnt;

    logic                  sof_beat;
    logic                  pass_en;
    logic                  s_tready;
    logic                  hs;
    logic                  advance;
    logic [CNT_WIDTH-1:0]  base_pix;
    logic [CNT_WIDTH-1:0]  base_line;
    logic [CNT_WIDTH-1:0]  pix_nxt;
    logic [CNT_WIDTH-1:0]  line_nxt;
    logic [FCNT_WIDTH-1:0] frame_cnt_nxt;
    logic                  line_err;
    logic                  short_err;
    logic                  frame_done;
    logic                  run_end;
    logic [USER_WIDTH-1:0] m_tuser;

    // tuser may be held high for many beats; only its rising edge across
    // accepted beats marks a start of frame.
    assign sof_beat = s_axis.tuser[0] & ~tuser_d;
    assign pass_en  = (state == PASS) |
                      ((state == WAIT_SOF) & s_axis.tvalid & sof_beat);

    // Zero-latency pass-through when open; drain the receiver when closed.
    assign s_tready      = pass_en ? m_axis.tready : 1'b1;
    assign s_axis.tready = s_tready;
    assign m_axis.tvalid = pass_en & s_axis.tvalid;
    assign m_axis.tdata  = s_axis.tdata;
    assign m_axis.tlast  = s_axis.tlast;

    always_comb begin
        m_tuser    = s_axis.tuser;
        m_tuser[0] = pass_en & sof_beat;
    end
    assign m_axis.tuser = m_tuser;

    assign hs = s_axis.tvalid & s_tready;

    // A stop in WAIT_SOF takes priority over a coincident start-of-frame.
    assign advance = pass_en & hs & ~((state == WAIT_SOF) & ctrl_stop);

    // A start-of-frame beat always restarts counting from zero, both on
    // the first frame and when it cuts a frame short.
    assign base_pix  = sof_beat ? '0 : pix_cnt;
    assign base_line = sof_beat ? '0 : line_cnt;
    assign pix_nxt   = (base_pix  == '1) ? base_pix  : base_pix  + 1'b1;
    assign line_nxt  = (base_line == '1) ? base_line : base_line + 1'b1;
    assign frame_cnt_nxt = frame_cnt + 1'b1;

    // Long lines flag when the width-th beat arrives without tlast; short
    // or long lines also flag at tlast when the count is off.
    assign line_err   = advance & (s_axis.tlast ? (pix_nxt != width_q)
                                                : (pix_nxt == width_q));
    assign short_err  = advance & (state == PASS) & sof_beat &
                        ((pix_cnt != '0) | (line_cnt != '0));
    assign frame_done = advance & s_axis.tlast & (line_nxt == height_q);
    assign run_end    = stop_pending | ctrl_stop |
                        ((num_frames_q != '0) & (frame_cnt_nxt == num_frames_q));

    assign sts_busy      = (state != IDLE);
    assign sts_frame_cnt = frame_cnt;

    always_ff @(posedge axis_clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            tuser_d           <= 1'b0;
            stop_pending      <= 1'b0;
            pix_cnt           <= '0;
            line_cnt          <= '0;
            width_q           <= '0;
            height_q          <= '0;
            num_frames_q      <= '0;
            frame_cnt         <= '0;
            sts_done          <= 1'b0;
            sts_err_line_len  <= 1'b0;
            sts_err_frame_len <= 1'b0;
        end else begin
            sts_done <= 1'b0;

            if (hs) begin
                tuser_d <= s_axis.tuser[0];
            end

            // New errors override a coincident clear.
            sts_err_line_len  <= (sts_err_line_len  & ~err_clear) | line_err;
            sts_err_frame_len <= (sts_err_frame_len & ~err_clear) | short_err;

            case (state)
                IDLE: begin
                    if (ctrl_start & ~ctrl_stop &
                        (cfg_width != '0) & (cfg_height != '0)) begin
                        width_q      <= cfg_width;
                        height_q     <= cfg_height;
                        num_frames_q <= cfg_num_frames;
                        frame_cnt    <= '0;
                        pix_cnt      <= '0;
                        line_cnt     <= '0;
                        stop_pending <= 1'b0;
                        state        <= WAIT_SOF;
                    end
                end
                WAIT_SOF: begin
                    if (ctrl_stop) begin
                        stop_pending <= 1'b0;
                        sts_done     <= 1'b1;
                        state        <= IDLE;
                    end
                end
                PASS: begin
                    if (ctrl_stop) begin
                        stop_pending <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Beat accounting; placed after the case so end-of-run wins
            // over a stop request raised on the same edge.
            if (advance) begin
                if (s_axis.tlast) begin
                    pix_cnt  <= '0;
                    line_cnt <= line_nxt;
                end else begin
                    pix_cnt  <= pix_nxt;
                    line_cnt <= base_line;
                end

                if (frame_done) begin
                    frame_cnt <= frame_cnt_nxt;
                    if (run_end) begin
                        stop_pending <= 1'b0;
                        sts_done     <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        state <= WAIT_SOF;
                    end
                end else begin
                    state <= PASS;
                end
            end
        end
    end

endmodule
